// File: rtl/inst_enc_pkg.sv
// Shared types and field layout for the MIPS instruction encoder/loader.
// Optional checking is enabled in the loader by defining INST_ENC_CHECK_EN.
package inst_enc_pkg;

    localparam int INST_W  = 32;
    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNC_W  = 6;
    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;

    // MSB position of each field inside the 32-bit word
    localparam int OP_MSB    = 31;
    localparam int RS_MSB    = 25;
    localparam int RT_MSB    = 20;
    localparam int RD_MSB    = 15;
    localparam int SHAMT_MSB = 10;
    localparam int FUNC_MSB  = 5;
    localparam int IMM_MSB   = 15;
    localparam int JADDR_MSB = 25;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_RSV = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_e;

endpackage

// File: rtl/inst_field_packer.sv
// Combinational encoder: decoded fields plus format code -> packed 32-bit MIPS word.
// Also flags bundles that are illegal (reserved format, or R-type with nonzero opcode).
module inst_field_packer
    import inst_enc_pkg::*;
(
    input  logic [1:0]         i_fmt,
    input  logic [OP_W-1:0]    i_op_code,
    input  logic [REG_W-1:0]   i_rs_addr,
    input  logic [REG_W-1:0]   i_rt_addr,
    input  logic [REG_W-1:0]   i_rd_addr,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [FUNC_W-1:0]  i_func,
    input  logic [IMM_W-1:0]   i_imm,
    input  logic [JADDR_W-1:0] i_address,
    output logic [INST_W-1:0]  o_word,
    output logic               o_illegal
);

    // Reserved format falls into the R-type layout; the loader decides whether to write it.
    always_comb begin
        o_word = '0;
        o_word[OP_MSB -: OP_W] = i_op_code;
        case (i_fmt)
            FMT_I: begin
                o_word[RS_MSB -: REG_W]  = i_rs_addr;
                o_word[RT_MSB -: REG_W]  = i_rt_addr;
                o_word[IMM_MSB -: IMM_W] = i_imm;
            end
            FMT_J: begin
                o_word[JADDR_MSB -: JADDR_W] = i_address;
            end
            default: begin
                o_word[RS_MSB -: REG_W]        = i_rs_addr;
                o_word[RT_MSB -: REG_W]        = i_rt_addr;
                o_word[RD_MSB -: REG_W]        = i_rd_addr;
                o_word[SHAMT_MSB -: SHAMT_W]   = i_shamt;
                o_word[FUNC_MSB -: FUNC_W]     = i_func;
            end
        endcase
    end

    assign o_illegal = (i_fmt == FMT_RSV) || ((i_fmt == FMT_R) && (i_op_code != '0));

endmodule

// File: rtl/inst_encode_loader.sv
// Loads packed MIPS instructions sequentially into instruction memory from address 0.
// Define INST_ENC_CHECK_EN to drop reserved-format bundles and report illegal ones on o_err.
module inst_encode_loader
    import inst_enc_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_finish,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [1:0]         i_fmt,
    input  logic [OP_W-1:0]    i_op_code,
    input  logic [REG_W-1:0]   i_rs_addr,
    input  logic [REG_W-1:0]   i_rt_addr,
    input  logic [REG_W-1:0]   i_rd_addr,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [FUNC_W-1:0]  i_func,
    input  logic [IMM_W-1:0]   i_imm,
    input  logic [JADDR_W-1:0] i_address,
    output logic               o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [INST_W-1:0]  o_mem_wdata,
    output logic [ADDR_W:0]    o_word_count,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              r_state;
    state_e              w_next_state;
    logic                w_transfer;
    logic                w_write;
    logic                w_clear;
    logic                w_done_next;
    logic                w_skip;
    logic                w_flag;
    logic [INST_W-1:0]   w_word;
    logic                w_illegal;

    logic [ADDR_W-1:0]   r_ptr;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [INST_W-1:0]   r_mem_wdata;
    logic [ADDR_W:0]     r_word_count;
    logic                r_done;
    logic                r_err;

    inst_field_packer u_packer (
        .i_fmt     (i_fmt),
        .i_op_code (i_op_code),
        .i_rs_addr (i_rs_addr),
        .i_rt_addr (i_rt_addr),
        .i_rd_addr (i_rd_addr),
        .i_shamt   (i_shamt),
        .i_func    (i_func),
        .i_imm     (i_imm),
        .i_address (i_address),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

`ifdef INST_ENC_CHECK_EN
    assign w_skip = (i_fmt == FMT_RSV);
    assign w_flag = w_illegal;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = w_illegal;
    assign w_skip = 1'b0;
    assign w_flag = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A finish coinciding with a transfer still lets that word through before ending.
    always_comb begin
        w_next_state = r_state;
        w_transfer   = 1'b0;
        w_write      = 1'b0;
        w_clear      = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_LOAD;
                    w_clear      = 1'b1;
                end
            end
            ST_LOAD: begin
                w_transfer = i_in_valid;
                w_write    = i_in_valid && !w_skip;
                if (i_finish) begin
                    w_next_state = ST_IDLE;
                    w_done_next  = 1'b1;
                end else if (w_write && (r_ptr == LAST_ADDR)) begin
                    w_next_state = ST_FULL;
                end
            end
            ST_FULL: begin
                if (i_finish) begin
                    w_next_state = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Write port is registered so address, data and strobe all appear one cycle after acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_mem_we <= w_write;
            r_done   <= w_done_next;
            if (w_clear) begin
                r_ptr        <= '0;
                r_word_count <= '0;
                r_err        <= 1'b0;
            end
            if (w_write) begin
                r_mem_addr   <= r_ptr;
                r_mem_wdata  <= w_word;
                r_ptr        <= r_ptr + 1'b1;
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_transfer && w_flag) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_in_ready   = (r_state == ST_LOAD);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_word_count = r_word_count;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Randomized scoreboard bench for inst_encode_loader with an arithmetic reference model.
// Model follows INST_ENC_CHECK_EN when it is defined for the build.
module tb_inst_encode_loader;

`ifdef INST_ENC_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [25:0] address;
    } bundle_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [6:0]  count;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        finish;
    logic        inValid;
    logic        inReady;
    logic [1:0]  fmt;
    logic [5:0]  opCode;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [4:0]  rdAddr;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [25:0] address;
    logic        memWe;
    logic [5:0]  memAddr;
    logic [31:0] memWdata;
    logic [6:0]  wordCount;
    logic        busy;
    logic        done;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    exp_t expQ[$];
    int   modelState;
    int   modelPtr;
    int   modelCount;
    bit   modelErr;

    inst_encode_loader #(.ADDR_W(6), .DEPTH(64)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_finish     (finish),
        .i_in_valid   (inValid),
        .o_in_ready   (inReady),
        .i_fmt        (fmt),
        .i_op_code    (opCode),
        .i_rs_addr    (rsAddr),
        .i_rt_addr    (rtAddr),
        .i_rd_addr    (rdAddr),
        .i_shamt      (shamt),
        .i_func       (func),
        .i_imm        (imm),
        .i_address    (address),
        .o_mem_we     (memWe),
        .o_mem_addr   (memAddr),
        .o_mem_wdata  (memWdata),
        .o_word_count (wordCount),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Field placement by plain arithmetic: each field scaled by 2**(its LSB position).
    function automatic logic [31:0] refPack(input bundle_t b);
        longint w;
        w = longint'(b.op) * 67108864;
        if (b.fmt == 2'd1)
            w += longint'(b.rs) * 2097152 + longint'(b.rt) * 65536 + longint'(b.imm);
        else if (b.fmt == 2'd2)
            w += longint'(b.address);
        else
            w += longint'(b.rs) * 2097152 + longint'(b.rt) * 65536 + longint'(b.rd) * 2048
               + longint'(b.shamt) * 64 + longint'(b.func);
        return w[31:0];
    endfunction

    function automatic bundle_t randBundle(input int maxFmt);
        bundle_t b;
        b.fmt     = 2'($urandom_range(maxFmt, 0));
        b.op      = 6'($urandom);
        b.rs      = 5'($urandom);
        b.rt      = 5'($urandom);
        b.rd      = 5'($urandom);
        b.shamt   = 5'($urandom);
        b.func    = 6'($urandom);
        b.imm     = 16'($urandom);
        b.address = 26'($urandom);
        return b;
    endfunction

    function automatic bundle_t mkBundle(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                                         input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                                         input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ad);
        bundle_t b;
        b.fmt = f; b.op = o; b.rs = s; b.rt = t; b.rd = d;
        b.shamt = sh; b.func = fn; b.imm = im; b.address = ad;
        return b;
    endfunction

    // Drive one cycle, advance the model across the clock edge, then compare status outputs.
    task automatic applyStimulus(input logic st, input logic fin, input logic vld, input bundle_t b);
        bit expDone;
        start = st; finish = fin; inValid = vld;
        fmt = b.fmt; opCode = b.op; rsAddr = b.rs; rtAddr = b.rt; rdAddr = b.rd;
        shamt = b.shamt; func = b.func; imm = b.imm; address = b.address;
        expDone = 1'b0;
        if (modelState == 0) begin
            if (st) begin
                modelState = 1; modelPtr = 0; modelCount = 0; modelErr = 1'b0;
            end
        end else if (modelState == 1) begin
            if (vld) begin
                if (CHECK && b.fmt == 2'd3) begin
                    modelErr = 1'b1;
                end else begin
                    expQ.push_back('{6'(modelPtr), refPack(b), 7'(modelCount + 1)});
                    modelPtr++;
                    modelCount++;
                    if (CHECK && b.fmt == 2'd0 && b.op != 6'd0) modelErr = 1'b1;
                end
            end
            if (fin) begin
                modelState = 0; expDone = 1'b1;
            end else if (modelPtr == 64) begin
                modelState = 2;
            end
        end else begin
            if (fin) begin
                modelState = 0; expDone = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("done", 32'(done), 32'(expDone));
        checkOutput("busy", 32'(busy), 32'(modelState != 0));
        checkOutput("in_ready", 32'(inReady), 32'(modelState == 1));
        checkOutput("word_count", 32'(wordCount), 32'(modelCount));
        checkOutput("err", 32'(err), 32'(modelErr));
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        expQ.delete();
        modelState = 0; modelPtr = 0; modelCount = 0; modelErr = 1'b0;
        #1;
        checkOutput("rst_mem_we", 32'(memWe), 32'd0);
        checkOutput("rst_mem_addr", 32'(memAddr), 32'd0);
        checkOutput("rst_mem_wdata", memWdata, 32'd0);
        checkOutput("rst_word_count", 32'(wordCount), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_in_ready", 32'(inReady), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && memWe) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", memAddr, memWdata);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("mem_addr", 32'(memAddr), 32'(e.addr));
                checkOutput("mem_wdata", memWdata, e.data);
                checkOutput("wr_word_count", 32'(wordCount), 32'(e.count));
            end
        end
    end

    initial begin
        bundle_t idle;
        idle = mkBundle(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; inValid = 1'b0;
        fmt = '0; opCode = '0; rsAddr = '0; rtAddr = '0; rdAddr = '0;
        shamt = '0; func = '0; imm = '0; address = '0;
        resetDut();

        $display("[TB] reset in the middle of a load session");
        applyStimulus(1'b1, 1'b0, 1'b0, idle);
        applyStimulus(1'b0, 1'b0, 1'b1, randBundle(2));
        inValid = 1'b1;
        resetDut();
        applyStimulus(1'b0, 1'b0, 1'b1, randBundle(2));

        $display("[TB] single R-type word");
        applyStimulus(1'b1, 1'b0, 1'b0, idle);
        applyStimulus(1'b0, 1'b0, 1'b1, mkBundle(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0));
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        $display("[TB] back-to-back I and J words");
        applyStimulus(1'b1, 1'b0, 1'b0, idle);
        applyStimulus(1'b0, 1'b0, 1'b1, mkBundle(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0));
        applyStimulus(1'b0, 1'b0, 1'b1, mkBundle(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10));
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        $display("[TB] fill all 64 words");
        applyStimulus(1'b1, 1'b0, 1'b0, idle);
        for (int i = 0; i < 64; i++) applyStimulus(1'b0, 1'b0, 1'b1, randBundle(2));
        applyStimulus(1'b1, 1'b0, 1'b1, randBundle(3));
        applyStimulus(1'b0, 1'b0, 1'b1, randBundle(3));
        applyStimulus(1'b0, 1'b1, 1'b0, idle);
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        $display("[TB] finish together with third transfer");
        applyStimulus(1'b1, 1'b0, 1'b0, idle);
        applyStimulus(1'b0, 1'b0, 1'b1, randBundle(2));
        applyStimulus(1'b0, 1'b0, 1'b1, randBundle(2));
        applyStimulus(1'b0, 1'b1, 1'b1, randBundle(2));
        applyStimulus(1'b0, 1'b0, 1'b1, randBundle(2));

        $display("[TB] reserved format");
        applyStimulus(1'b1, 1'b0, 1'b0, idle);
        applyStimulus(1'b0, 1'b0, 1'b1, randBundle(2));
        applyStimulus(1'b0, 1'b0, 1'b1, mkBundle(2'd3, 6'h15, 5'd4, 5'd5, 5'd6, 5'd7, 6'h2A, 16'd0, 26'd0));
        applyStimulus(1'b0, 1'b0, 1'b1, mkBundle(2'd0, 6'd0, 5'd9, 5'd8, 5'd7, 5'd1, 6'h22, 16'd0, 26'd0));
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        $display("[TB] random sessions");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(7, 0) == 0), ($urandom_range(29, 0) == 0),
                          ($urandom_range(3, 0) != 0), randBundle(3));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, idle);
        applyStimulus(1'b0, 1'b0, 1'b0, idle);
        applyStimulus(1'b0, 1'b0, 1'b0, idle);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_encode_loader.md
Name: inst_encode_loader

Overview:
Write-side counterpart of the instruction fetch path. Accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit MIPS-format words (R/I/J), and writes them sequentially into the 64x32 instruction memory. It is used to load the program into instruction memory before the fetch unit runs from address 0.

Parameters:
ADDR_W, 6, instruction memory address width.
DEPTH, 64, number of words; must equal 2**ADDR_W.

Ports:
clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
start  input  1  IDLE only: begin a load session at address 0.
finish  input  1  LOAD only: end the session early.
in_valid  input  1  field bundle valid.
in_ready  output  1  loader can accept a bundle.
fmt  input  2  0=R, 1=I, 2=J, 3=reserved.
op_code  input  6  opcode.
rs_addr  input  5  rs field.
rt_addr  input  5  rt field.
rd_addr  input  5  rd field (R only).
shamt  input  5  shift amount (R only).
func  input  6  function code (R only).
imm  input  16  immediate (I only).
address  input  26  jump target (J only).
mem_we  output  1  memory write strobe, one cycle.
mem_addr  output  ADDR_W  write address.
mem_wdata  output  32  packed instruction word.
word_count  output  ADDR_W+1  words written in the current session.
busy  output  1  high in LOAD or FULL.
done  output  1  one-cycle pulse when a session ends.
err  output  1  sticky illegal-format flag; 0 unless INST_ENC_CHECK_EN is defined.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; in_ready, mem_we, busy, done, err=0; mem_addr=0; mem_wdata=0; word_count=0; write pointer=0.
- States:
  - IDLE: in_ready=0. When start=1, go to LOAD, clear pointer, word_count, and err.
  - LOAD: in_ready=1. A transfer happens when in_valid & in_ready.
    - On a transfer at edge N: mem_we=1, mem_addr=pointer, and mem_wdata=packed word are registered. They are visible for exactly the cycle after edge N (1-cycle latency).
    - The pointer increments on the same edge.
    - Throughput is one word per cycle.
  - FULL: entered on the transfer that uses address DEPTH-1. in_ready=0 and further in_valid is ignored. When finish=1, go to IDLE with done pulsed.
- Session end from LOAD on finish=1: go to IDLE and pulse done.
  - If finish and a transfer coincide, the word is accepted and written first.
  - word_count includes that final word.
- Packing (fields truncated to their widths):
  - R: {op_code, rs_addr, rt_addr, rd_addr, shamt, func}
  - I: {op_code, rs_addr, rt_addr, imm}
  - J: {op_code, address}
- Write pointer: no wrap. After address DEPTH-1 the block must pass through FULL; it never overwrites address 0 within a session.
- word_count: increments with each mem_we pulse; range 0..DEPTH. It holds its value in IDLE until the next start.
- Ignored inputs: start outside IDLE, and finish in IDLE.
- Reset mid-session: all state is discarded immediately; any pending mem_we is cancelled.

Optional Feature:
INST_ENC_CHECK_EN
- Defined:
  - fmt=3 is reserved. The handshake still completes, but no write occurs and the pointer and word_count are unchanged.
  - err sets and stays set until the next start or reset.
  - R-type with op_code != 0 is also flagged in err, but that word is still written.
- Not defined:
  - fmt=3 packs as R-type.
  - err is tied to 0.

Decomposition:
- Shared package inst_enc_pkg:
  - format codes FMT_R/FMT_I/FMT_J/FMT_RSV.
  - field widths and bit positions (OP_MSB=31, RS_MSB=25, RT_MSB=20, RD_MSB=15, SHAMT_MSB=10, FUNC_MSB=5).
  - state encoding ST_IDLE/ST_LOAD/ST_FULL.
- One sub-module, inst_field_packer: purely combinational fields+fmt -> 32-bit word (plus illegal flag), reusable by testbenches as a golden encoder.

Test Plan:
1. Reset=0 mid-LOAD with in_valid=1 -> all outputs zero next sample; mem_we never asserts; state IDLE.
2. start, then R-bundle (op=0, rs=1, rt=2, rd=3, shamt=0, func=0x20) -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820, word_count=1.
3. I-bundle (op=0x08, rs=1, rt=2, imm=0xFFFF) then J-bundle (op=0x02, address=0x0000010) back-to-back -> writes 0x2022FFFF at addr 0 and 0x08000010 at addr 1 on consecutive cycles.
4. 64 consecutive bundles -> writes addresses 0..63; in_ready=0 after the 64th transfer; 65th in_valid produces no write; word_count=64; finish -> done pulse, IDLE.
5. finish coincident with 3rd transfer -> 3rd word written at addr 2; done pulses; word_count=3; state IDLE.
6. fmt=3 with macro defined -> no write, err=1, pointer unchanged. Without macro -> word written as R-type, err=0.
